// File: rtl/nn_pipe_pkg.sv
// Shared constants and helpers for the N-stage pipeline handshake controller.
package nn_pipe_pkg;

    localparam int DEF_NUM_STAGES = 3;
    localparam int DEF_CNT_W      = 16;

    // Ceiling log2 used to size the occupancy counter; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int x;
        r = 0;
        x = n - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_pipe_slot.sv
// One stage valid bit: frees when empty or when its occupant can move on,
// loads when fed and free; all state drops on flush.
module nn_pipe_slot (
    input  logic clk,
    input  logic reset,
    input  logic feed,
    input  logic free_next,
    input  logic flush,
    output logic v,
    output logic free,
    output logic en
);

    assign free = !v | free_next;
    assign en   = feed & free & !flush;

    // The occupant leaves exactly when the slot ahead can take it (or the consumer does).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= 1'b0;
        end else begin
            v <= !flush & (en | (v & !free_next));
        end
    end

endmodule

// File: rtl/nn_pipe_ctrl.sv
// Bubble-collapsing valid/ready controller for an N-stage datapath with
// flush, occupancy tracking and a saturating output-stall counter.
module nn_pipe_ctrl
    import nn_pipe_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             flush,
    output logic [NUM_STAGES-1:0]            stage_en,
    output logic [NUM_STAGES-1:0]            stage_vld,
    output logic [clog2(NUM_STAGES+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]                 stall_cnt
);

    localparam int OCC_W = clog2(NUM_STAGES + 1);

    logic take_out;
    logic acc;

    assign take_out  = stage_vld[NUM_STAGES-1] & out_ready;
    assign out_valid = stage_vld[NUM_STAGES-1];
    assign acc       = in_valid & in_ready;

    // Free chain runs from the output slot back to the input slot through
    // per-slot scalars so each link stays a distinct net.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
        logic free_o;
        logic free_nx;
        logic feed_i;

        if (i == NUM_STAGES - 1) begin : g_last
            assign free_nx = take_out;
        end else begin : g_mid
            assign free_nx = g_slot[i+1].free_o;
        end

        if (i == 0) begin : g_first
            assign feed_i = acc;
        end else begin : g_rest
            assign feed_i = stage_vld[i-1];
        end

        nn_pipe_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .feed      (feed_i),
            .free_next (free_nx),
            .flush     (flush),
            .v         (stage_vld[i]),
            .free      (free_o),
            .en        (stage_en[i])
        );
    end

    assign in_ready = g_slot[0].free_o & !flush & !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(acc) - OCC_W'(take_out);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
